// File: rtl/bus_sequencer.sv
// Register-transfer bus sequencer: queues {source, destination} requests in a FIFO
// and replays each one as a DRIVE then LATCH sequence on the shared bus.
module bus_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_src,
  input  logic [2:0] req_dst,
  output logic       req_ready,
  output logic [3:0] read_en,
  output logic [7:0] wr_en,
  output logic       done,
  output logic       err,
  output logic [7:0] xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LATCH
  } state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          push;
  logic          pop;
  logic [3:0]    head_src;
  logic [2:0]    head_dst;
  logic          head_ok;

  assign push     = rst_n && req_valid && req_ready;
  assign pop      = (state == LATCH);
  assign head_src = mem[rd_ptr][6:3];
  assign head_dst = mem[rd_ptr][2:0];

  always_comb begin
    next_count = count + CW'(push) - CW'(pop);
  end

  // Only these codes select a real register onto the bus; anything else is discarded.
  always_comb begin
    head_ok = 1'b0;
    case (head_src)
      4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13: head_ok = 1'b1;
      default: head_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_src, req_dst};
    end
  end

  // Outputs are decoded from the current state, so they trail the state by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      req_ready  <= 1'b0;
      read_en    <= 4'd0;
      wr_en      <= 8'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= next_count;
      req_ready <= (next_count != CW'(DEPTH));
      read_en   <= 4'd0;
      wr_en     <= 8'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= DRIVE;
          end
        end
        DRIVE: begin
          state <= LATCH;
          if (head_ok) begin
            read_en <= head_src;
          end
        end
        LATCH: begin
          if (head_ok) begin
            read_en    <= head_src;
            wr_en      <= 8'd1 << head_dst;
            done       <= 1'b1;
            xfer_count <= xfer_count + 8'd1;
          end else begin
            err <= 1'b1;
          end
          state <= (next_count != '0) ? DRIVE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: accepted requests feed an expected-transfer queue
// that a negedge monitor drains whenever the DUT shows a completion or discard.
module tb_bus_sequencer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_src;
  logic [2:0] req_dst;
  logic       req_ready;
  logic [3:0] read_en;
  logic [7:0] wr_en;
  logic       done;
  logic       err;
  logic [7:0] xfer_count;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  int         pushed_cnt = 0;
  int         completed_cnt = 0;
  int         completed_valid = 0;
  bit         in_reset = 1;
  bit         record_on = 0;
  logic [3:0] rd_log[$];
  logic [7:0] wr_log[$];

  bus_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .read_en   (read_en),
    .wr_en     (wr_en),
    .done      (done),
    .err       (err),
    .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_valid_src(input logic [3:0] s);
    return s inside {4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13};
  endfunction

  function automatic logic [3:0] pick_valid_src();
    logic [3:0] table_src [8];
    table_src = '{4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13};
    return table_src[$urandom_range(0, 7)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of request inputs mid-cycle; records the push if the handshake completes.
  task automatic applyStimulus(input logic v, input logic [3:0] s, input logic [2:0] d, output bit acc);
    @(negedge clk);
    #1;
    req_valid = v;
    req_src   = s;
    req_dst   = d;
    acc = v && req_ready && rst_n;
    if (acc) begin
      exp_q.push_back({s, d});
      pushed_cnt++;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    in_reset  = 1;
    exp_q.delete();
    pushed_cnt      = 0;
    completed_cnt   = 0;
    completed_valid = 0;
    @(posedge clk);
    #2;
    checkOutput("reset_outputs", {req_ready, read_en, wr_en, done, err, xfer_count}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    in_reset = 0;
  endtask

  task automatic drainQueue();
    bit acc;
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      applyStimulus(1'b0, 4'd0, 3'd0, acc);
      n++;
    end
    repeat (3) applyStimulus(1'b0, 4'd0, 3'd0, acc);
    checkOutput("drain", exp_q.size(), 0);
    checkOutput("idle_xfer_count", xfer_count, completed_valid % 256);
    checkOutput("idle_ready", req_ready, 1);
  endtask

  // Monitor: every visible completion or discard must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [6:0]  e;
    logic [13:0] exp_t;
    if (!in_reset) begin
      if (done || err || wr_en != 8'd0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", {done, err, wr_en}, 0);
        end else begin
          e = exp_q.pop_front();
          completed_cnt++;
          if (is_valid_src(e[6:3])) begin
            completed_valid++;
            exp_t = {e[6:3], 8'(1 << e[2:0]), 1'b1, 1'b0};
          end else begin
            exp_t = {4'd0, 8'd0, 1'b0, 1'b1};
          end
          checkOutput("transfer", {read_en, wr_en, done, err}, exp_t);
          checkOutput("xfer_count", xfer_count, completed_valid % 256);
        end
      end else if (exp_q.size() == 0) begin
        checkOutput("idle_read_en", read_en, 0);
      end
      checkOutput("req_ready", req_ready, (pushed_cnt - completed_cnt) != DEPTH);
    end
    if (record_on) begin
      rd_log.push_back(read_en);
      wr_log.push_back(wr_en);
    end
  end

  initial begin
    bit         acc;
    int         stalls;
    int         sent;
    int         tries;
    int         first;
    logic [3:0] b_src [4];
    logic [2:0] b_dst [4];
    logic [3:0] s_exp_rd [5];
    logic [7:0] s_exp_wr [5];
    logic       s_exp_done [5];

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_src   = 4'd0;
    req_dst   = 3'd0;
    applyReset();
    checkOutput("ready_after_reset", req_ready, 1);

    // Single transfer with exact edge-by-edge latency.
    s_exp_rd   = '{4'd0, 4'd0, 4'd5, 4'd5, 4'd0};
    s_exp_wr   = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
    s_exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    applyStimulus(1'b1, 4'd5, 3'd4, acc);
    checkOutput("single_accept", acc, 1);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("single_read_en", read_en, s_exp_rd[k]);
      checkOutput("single_wr_en", wr_en, s_exp_wr[k]);
      checkOutput("single_done", done, s_exp_done[k]);
      @(posedge clk);
      #2;
    end
    drainQueue();
    checkOutput("single_count", xfer_count, 1);

    // Burst of four: back-to-back read_en with no zero gap, wr_en every other cycle.
    b_src = '{4'd7, 4'd8, 4'd9, 4'd10};
    for (int i = 0; i < 4; i++) b_dst[i] = 3'($urandom_range(0, 7));
    rd_log.delete();
    wr_log.delete();
    record_on = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, b_src[i], b_dst[i], acc);
      checkOutput("burst_accept", acc, 1);
    end
    drainQueue();
    record_on = 0;
    first = -1;
    for (int i = 0; i < rd_log.size(); i++) begin
      if (first < 0 && rd_log[i] != 4'd0) first = i;
    end
    checkOutput("burst_started", first >= 0 && first + 8 < rd_log.size(), 1);
    if (first >= 0 && first + 8 < rd_log.size()) begin
      for (int j = 0; j < 8; j++) begin
        checkOutput("burst_read_en", rd_log[first + j], b_src[j / 2]);
        checkOutput("burst_wr_en", wr_log[first + j], (j % 2 == 1) ? (32'd1 << b_dst[j / 2]) : 32'd0);
      end
      checkOutput("burst_tail", rd_log[first + 8], 0);
    end

    // Fill past DEPTH: the bench must see at least one refused cycle.
    stalls = 0;
    sent   = 0;
    tries  = 0;
    while (sent < 6 && tries < 40) begin
      applyStimulus(1'b1, pick_valid_src(), 3'($urandom_range(0, 7)), acc);
      if (acc) sent++;
      else stalls++;
      tries++;
    end
    checkOutput("fill_sent", sent, 6);
    checkOutput("fill_stalled", stalls > 0, 1);
    drainQueue();

    // Invalid source followed by a normal one.
    applyStimulus(1'b1, 4'd6, 3'd3, acc);
    checkOutput("invalid_accept", acc, 1);
    applyStimulus(1'b1, 4'd5, 3'd0, acc);
    checkOutput("after_invalid_accept", acc, 1);
    drainQueue();

    // Randomized traffic including invalid source codes.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : pick_valid_src(),
                    3'($urandom_range(0, 7)), acc);
    end
    drainQueue();

    // Reset while the second of four queued transfers is in DRIVE.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, pick_valid_src(), 3'($urandom_range(0, 7)), acc);
      checkOutput("abort_accept", acc, 1);
    end
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'd0, 3'd0, acc);
    checkOutput("post_reset_read_en", read_en, 0);
    checkOutput("post_reset_count", xfer_count, 0);
    checkOutput("post_reset_ready", req_ready, 1);

    // 256 valid transfers wrap the counter back to zero.
    sent  = 0;
    tries = 0;
    while (sent < 256 && tries < 2000) begin
      applyStimulus(1'b1, pick_valid_src(), 3'($urandom_range(0, 7)), acc);
      if (acc) sent++;
      tries++;
    end
    checkOutput("wrap_sent", sent, 256);
    drainQueue();
    checkOutput("wrap_count", xfer_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
